// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the one-hot-write register file.
//   NUM_REGS            : number of architectural registers (r0 is hardwired 0)
//   ADDR_WIDTH          : width of a binary register index
//   DEFAULT_DATA_WIDTH  : default register / data port width
//   sel_class_e         : classification of the one-hot write select
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int NUM_REGS           = 32;
   localparam int ADDR_WIDTH         = 5;
   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      SEL_LEGAL = 2'd0,   // exactly one bit set
      SEL_ZERO  = 2'd1,   // no bits set
      SEL_MULTI = 2'd2    // two or more bits set
   } sel_class_e;

endpackage : regfile_pkg

// File: rtl/regfile_onehot_wr_onehot_check.sv
// -----------------------------------------------------------------------------
// onehot_check
// Purely combinational classifier of the decoder's one-hot write select.
// Ports:
//   sel_i        in  NUM_REGS  write select, bit i selects register i
//   sel_class_o  out enum      SEL_LEGAL / SEL_ZERO / SEL_MULTI
// -----------------------------------------------------------------------------
module onehot_check
   import regfile_pkg::*;
(
   input  logic [NUM_REGS-1:0] sel_i,
   output sel_class_e          sel_class_o
);

   localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   logic [NUM_REGS-1:0] low_cleared;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the block leaves it unassigned (which would infer a latch).
      sel_class_o = SEL_MULTI;
      low_cleared = sel_i & (sel_i - ONE);
      if (sel_i == '0) begin
         sel_class_o = SEL_ZERO;
      end else if (low_cleared == '0) begin
         sel_class_o = SEL_LEGAL;
      end
   end

endmodule : onehot_check

// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
// 32 x DATA_WIDTH register file written through a one-hot select coming
// straight from the write-address decoder, with two registered read ports.
// Illegal selects (none or several bits set) are suppressed, flagged with a
// one-cycle wr_err pulse and counted in a saturating err_count.
// r0 is hardwired to zero and has no storage; writes to it are dropped quietly.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  defined   : a legal write to index i != 0 is forwarded
//                                  to a read port addressing i at the same edge
//                      undefined : same-edge reads return the old contents
//
// Ports:
//   clock      in   1              rising-edge clock
//   reset_n    in   1              asynchronous active-low reset
//   wr_en      in   1              global write strobe
//   wr_sel     in   32             one-hot register select
//   wr_data    in   DATA_WIDTH     write data
//   rd_addr_a  in   5              read port A index
//   rd_addr_b  in   5              read port B index
//   rd_data_a  out  DATA_WIDTH     read port A data (1-cycle latency)
//   rd_data_b  out  DATA_WIDTH     read port B data (1-cycle latency)
//   wr_err     out  1              illegal-write pulse (registered)
//   err_count  out  ERR_CNT_WIDTH  saturating illegal-write count
// -----------------------------------------------------------------------------
module regfile_onehot_wr
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [NUM_REGS-1:0]      wr_sel,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [ADDR_WIDTH-1:0]    rd_addr_a,
   input  logic [ADDR_WIDTH-1:0]    rd_addr_b,
   output logic [DATA_WIDTH-1:0]    rd_data_a,
   output logic [DATA_WIDTH-1:0]    rd_data_b,
   output logic                     wr_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   // ---------------------------------------------------------------------------
   // Select classification
   // ---------------------------------------------------------------------------
   sel_class_e sel_class;

   onehot_check u_onehot_check (
      .sel_i       (wr_sel),
      .sel_class_o (sel_class)
   );

   logic wr_legal;
   logic wr_illegal;

   // wr_sel is ignored entirely when the strobe is low.
   assign wr_legal   = wr_en && (sel_class == SEL_LEGAL);
   assign wr_illegal = wr_en && (sel_class != SEL_LEGAL);

   // ---------------------------------------------------------------------------
   // Storage: r1..r31 only; r0 has no flops.
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];

   // NOTE: the storage array is cleared by reset because the register file must
   // read back zero after reset; a reset that lands mid-write wins over the write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // A legal select has one bit, so at most one register loads; bit 0
         // has no storage and is dropped here without an error.
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_legal && wr_sel[i]) begin
               // NOTE: sequential state uses non-blocking assignment so every
               // flop samples pre-edge values, independent of statement order.
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read muxing (next-state of the registered read data)
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rd_data_a_d, rd_data_a_q;
   logic [DATA_WIDTH-1:0] rd_data_b_d, rd_data_b_q;

   always_comb begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      // Index 0 never matches the loop, so it reads as zero.
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rd_addr_a == ADDR_WIDTH'(i)) rd_data_a_d = regs_q[i];
         if (rd_addr_b == ADDR_WIDTH'(i)) rd_data_b_d = regs_q[i];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward only legal writes and never to index 0.
      if (wr_legal && (rd_addr_a != '0) && wr_sel[rd_addr_a]) rd_data_a_d = wr_data;
      if (wr_legal && (rd_addr_b != '0) && wr_sel[rd_addr_b]) rd_data_b_d = wr_data;
`endif
   end

   // ---------------------------------------------------------------------------
   // Error reporting
   // ---------------------------------------------------------------------------
   logic                     wr_err_d, wr_err_q;
   logic [ERR_CNT_WIDTH-1:0] err_count_d, err_count_q;

   always_comb begin
      wr_err_d    = wr_illegal;
      err_count_d = err_count_q;
      // Saturate at all-ones rather than wrapping.
      if (wr_illegal && (err_count_q != '1)) begin
         err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         wr_err_q    <= 1'b0;
         err_count_q <= '0;
      end else begin
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         wr_err_q    <= wr_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign wr_err    = wr_err_q;
   assign err_count = err_count_q;

endmodule : regfile_onehot_wr

// File: tb/tb_regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// tb_regfile_onehot_wr
// Self-checking bench for regfile_onehot_wr. A reference model (array of
// register values, error counter) is advanced once per clock edge from the
// input rules and compared against every DUT output after each edge.
// Honours REGFILE_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_regfile_onehot_wr;

   localparam int DW  = 32;
   localparam int ECW = 8;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          wr_en;
   logic [31:0]   wr_sel;
   logic [DW-1:0] wr_data;
   logic [4:0]    rd_addr_a;
   logic [4:0]    rd_addr_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic          wr_err;
   logic [ECW-1:0] err_count;

   regfile_onehot_wr #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(ECW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .wr_err    (wr_err),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [DW-1:0] model [32];
   int            m_cnt;
   logic          m_err;
   logic [DW-1:0] m_rd_a, m_rd_b;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
      m_cnt  = 0;
      m_err  = 1'b0;
      m_rd_a = '0;
      m_rd_b = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rd_a"},  64'(rd_data_a), 64'(m_rd_a));
      check({tag, ".rd_b"},  64'(rd_data_b), 64'(m_rd_b));
      check({tag, ".err"},   64'(wr_err),    64'(m_err));
      check({tag, ".count"}, 64'(err_count), 64'(m_cnt));
   endtask

   // One clock edge: compute what the edge must produce from the current
   // inputs, let the edge happen, update the model, compare.
   task automatic tick(input string tag);
      int  pop;
      logic legal;
      pop   = $countones(wr_sel);
      legal = wr_en && (pop == 1);
      m_rd_a = (rd_addr_a == 0) ? '0 : model[rd_addr_a];
      m_rd_b = (rd_addr_b == 0) ? '0 : model[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (legal && rd_addr_a != 0 && wr_sel[rd_addr_a]) m_rd_a = wr_data;
      if (legal && rd_addr_b != 0 && wr_sel[rd_addr_b]) m_rd_b = wr_data;
`endif
      @(posedge clock);
      #1;
      m_err = wr_en && (pop != 1);
      if (m_err && m_cnt < 255) m_cnt++;
      if (legal) begin
         for (int i = 1; i < 32; i++) if (wr_sel[i]) model[i] = wr_data;
      end
      check_all(tag);
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      wr_sel  = '0;
      wr_data = '0;
   endtask

   // Pulse reset while whatever is on the inputs is being presented across an edge.
   task automatic reset_pulse(input string tag);
      reset_n = 1'b0;
      #2;
      model_clear();
      check_all({tag, ".async"});
      @(posedge clock);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, bit_i;

      reset_n   = 1'b0;
      idle();
      rd_addr_a = '0;
      rd_addr_b = '0;
      model_clear();
      #7;
      check_all("reset");
      #10;
      reset_n = 1'b1;

      // Every register reads zero after reset, through both ports.
      for (int a = 0; a < 32; a++) begin
         rd_addr_a = 5'(a);
         rd_addr_b = 5'(31 - a);
         tick("rst_read");
      end

      // Reset asserted during a write to r5 aborts it.
      wr_en = 1'b1; wr_sel = 32'h0000_0020; wr_data = 32'hDEAD_BEEF;
      rd_addr_a = 5'd5;
      reset_pulse("rst_mid_write");
      idle();
      tick("r5_after_rst");
      tick("r5_after_rst2");
      check("r5_zero", 64'(rd_data_a), 64'h0);

      // Basic write / read.
      wr_en = 1'b1; wr_sel = 32'h0000_0008; wr_data = 32'hA5A5_A5A5;
      rd_addr_a = 5'd1; rd_addr_b = 5'd0;
      tick("wr_r3");
      idle();
      rd_addr_a = 5'd3;
      tick("rd_r3");
      check("rd_r3_value", 64'(rd_data_a), 64'hA5A5_A5A5);
      check("rd_r0_value", 64'(rd_data_b), 64'h0);

      // r0 write is dropped silently.
      wr_en = 1'b1; wr_sel = 32'h0000_0001; wr_data = 32'hFFFF_FFFF;
      rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      tick("wr_r0");
      idle();
      tick("rd_r0");
      check("r0_still_zero", 64'(rd_data_a), 64'h0);
      check("r0_no_err",     64'(wr_err),    64'h0);

      // MULTI select.
      rd_addr_a = 5'd4; rd_addr_b = 5'd8;
      wr_en = 1'b1; wr_sel = 32'h0000_0110; wr_data = 32'h0000_1234;
      tick("multi");
      check("multi_err",   64'(wr_err),    64'h1);
      check("multi_count", 64'(err_count), 64'h1);
      // ZERO select.
      wr_sel = '0;
      tick("zero");
      check("zero_count", 64'(err_count), 64'h2);
      // Strobe low with a MULTI pattern: no error.
      wr_en = 1'b0; wr_sel = 32'h0000_0003;
      tick("noen");
      check("noen_err", 64'(wr_err), 64'h0);
      idle();
      tick("r4_r8_read");
      check("r4_unchanged", 64'(rd_data_a), 64'h0);
      check("r8_unchanged", 64'(rd_data_b), 64'h0);

      // Same-edge collision on r7.
      wr_en = 1'b1; wr_sel = 32'h0000_0080; wr_data = 32'h11;
      tick("r7_init");
      rd_addr_a = 5'd7; wr_data = 32'h55;
      tick("r7_collide");
`ifdef REGFILE_BYPASS_EN
      check("collide_fwd", 64'(rd_data_a), 64'h55);
`else
      check("collide_old", 64'(rd_data_a), 64'h11);
`endif
      idle();
      tick("r7_after");
      check("collide_new", 64'(rd_data_a), 64'h55);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         wr_en   = ($urandom_range(0, 3) != 0);
         wr_data = $urandom;
         kind    = $urandom_range(0, 9);
         bit_i   = $urandom_range(0, 31);
         rd_addr_a = 5'($urandom_range(0, 31));
         rd_addr_b = 5'($urandom_range(0, 31));
         if (kind < 6) begin
            wr_sel = 32'h1 << bit_i;
            if ($urandom_range(0, 1) == 1) rd_addr_a = 5'(bit_i);
            if ($urandom_range(0, 3) == 0) rd_addr_b = 5'(bit_i);
         end else if (kind == 6) begin
            wr_sel = '0;
         end else begin
            wr_sel = $urandom;
         end
         tick("rand");
      end

      // Saturation: 300 consecutive MULTI writes.
      rd_addr_a = 5'd3; rd_addr_b = 5'd7;
      for (int n = 0; n < 300; n++) begin
         wr_en   = 1'b1;
         wr_sel  = 32'h3 << $urandom_range(0, 30);
         wr_data = $urandom;
         tick("sat");
      end
      check("sat_count", 64'(err_count), 64'hFF);
      check("sat_err",   64'(wr_err),    64'h1);
      wr_sel = '0;
      tick("sat_hold");
      check("sat_hold_count", 64'(err_count), 64'hFF);
      idle();
      tick("sat_idle");
      check("sat_idle_err", 64'(wr_err), 64'h0);

      // Reset clears storage and the counter, even mid-write.
      wr_en = 1'b1; wr_sel = 32'h0000_0008; wr_data = 32'hCAFE_F00D;
      rd_addr_a = 5'd3;
      reset_pulse("rst_after_sat");
      idle();
      tick("post_rst");
      check("post_rst_count", 64'(err_count), 64'h0);
      check("post_rst_r3",    64'(rd_data_a), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_regfile_onehot_wr

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32-entry by DATA_WIDTH register file for the processor datapath.
- Sits directly downstream of the 5-to-32 write-address decoder. It consumes the decoder's one-hot 32-bit output as the per-register write select.
- Provides two synchronous read ports, each addressed by a 5-bit binary index.
- Validates that the write select is legal one-hot. Illegal writes are suppressed and counted.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ERR_CNT_WIDTH, 8, width of the saturating illegal-write counter.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  global write strobe.
- wr_sel  input  32  one-hot register select from the decoder; bit i selects register i.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr_a  input  5  read port A index.
- rd_addr_b  input  5  read port B index.
- rd_data_a  output  DATA_WIDTH  read port A data, registered.
- rd_data_b  output  DATA_WIDTH  read port B data, registered.
- wr_err  output  1  one-cycle pulse flagging an illegal write attempt.
- err_count  output  ERR_CNT_WIDTH  saturating count of illegal writes.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - all 31 storage registers clear to 0;
  - rd_data_a, rd_data_b, wr_err and err_count clear to 0;
  - reset asserted mid-write aborts that write; no partial update.
- Register 0:
  - hardwired zero, no storage;
  - reads of index 0 always return 0.
- Write-select classification, evaluated combinationally each cycle while wr_en=1:
  - LEGAL: exactly one bit of wr_sel set;
  - ZERO: no bits set;
  - MULTI: two or more bits set.
- Write, at the rising edge:
  - LEGAL with bit i ≠ 0: register i <= wr_data.
  - LEGAL with bit 0: silently dropped; no error.
  - ZERO or MULTI: no register changes.
  - wr_en=0: wr_sel is ignored entirely; no write, no error.
- Error reporting:
  - wr_err is registered. It is 1 in the cycle after the edge that sampled wr_en=1 with ZERO or MULTI; otherwise 0.
  - Back-to-back illegal writes hold wr_err high continuously.
  - err_count increments at that same edge and saturates at all-ones (255 by default). No wrap.
- Read:
  - latency is 1 cycle; rd_data_x <= value of register rd_addr_x at the rising edge;
  - both ports are independent and may address the same register.
- Same-edge write and read of the same index: governed by the optional feature below.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - a LEGAL write to index i ≠ 0 forwards wr_data to any read port whose address is i at the same edge;
  - the port therefore returns the new value with 1-cycle latency.
  - Index 0 is never forwarded.
  - Illegal writes are never forwarded.
- Undefined: a same-edge read returns the pre-write contents; the new value is visible one cycle later.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS = 32 and ADDR_WIDTH = 5;
  - the write-select classification enum {SEL_LEGAL, SEL_ZERO, SEL_MULTI};
  - the default DATA_WIDTH constant.
- One natural sub-module, onehot_check: a purely combinational classifier of the 32-bit select that outputs the classification enum.
- Storage and read muxing stay in the top.

Test Plan:
- Reset mid-write: reset_n low, every register reads 0 and err_count=0. Next, pulse reset_n low during a write of 0xDEADBEEF to r5 → r5 reads 0 after release.
- Basic write/read: write 0xA5A5A5A5 with wr_sel=0x00000008 (r3), then rd_addr_a=3 → rd_data_a=0xA5A5A5A5 one cycle after the address is sampled. Also set rd_addr_b=0 → rd_data_b=0.
- r0 write: wr_sel=0x00000001, wr_data=0xFFFFFFFF → r0 still reads 0, wr_err stays 0, err_count unchanged.
- Illegal selects:
  - wr_sel=0x00000110 with wr_data=0x1234 → r4 and r8 unchanged, wr_err=1 for one cycle, err_count=1;
  - then wr_sel=0 with wr_en=1 → err_count=2;
  - then wr_en=0 with wr_sel=0x3 → no error.
- Saturation: 300 consecutive MULTI writes → err_count=255 and holds; wr_err high throughout.
- Same-edge collision: write 0x55 to r7 while rd_addr_a=7, where r7 previously held 0x11.
  - With REGFILE_BYPASS_EN: rd_data_a=0x55 next cycle.
  - Without it: rd_data_a=0x11 next cycle, then 0x55 the cycle after.
